int_issue_rfread: RTL
=====================

# int_issue_rfread

Regfile-read stage on the far side of the integer reservation station's issue interface. Each cycle it takes the entries the RS selected the previous cycle, checks their sources against the physical-register ready table, and allocates a limited pool of regfile read ports. In the same cycle it returns per-port dequeue or replay feedback to the RS. One cycle later it presents the operand-complete micro-op to the functional units.

## Interface
Parameters:
- DEPTH, 8: RS depth; index width is $clog2(DEPTH).
- INOUTPORT_NUM, 2: issue lanes; must match the RS.
- NUMSRCS, 2: sources per micro-op (`NUMSRCS_INT).
- RFREAD_PORTS, 3: regfile read ports shared by all lanes; may be fewer than INOUTPORT_NUM*NUMSRCS.
- WBPORT_NUM, 6: writeback ports.
- PRF_NUM, 64: physical registers; iprIdx_t indexes them.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_can_issue  in  INOUTPORT_NUM  RS lane holds a selected entry.
- i_issue_idx  in  INOUTPORT_NUM x $clog2(DEPTH)  RS entry index per lane.
- i_issue_info  in  RSdeqInfo_t[INOUTPORT_NUM]  micOp_type, rsIdx[NUMSRCS], src_use[NUMSRCS], rdIdx, rd_wen, imm.
- o_feedback_idx  out  INOUTPORT_NUM x $clog2(DEPTH)  echo of i_issue_idx.
- o_deq_vld  out  INOUTPORT_NUM  lane accepted; RS frees the entry.
- o_replay_vld  out  INOUTPORT_NUM  lane rejected; RS clears the issued bit.
- i_prf_rdy  in  PRF_NUM  committed ready bit per physical register.
- i_fu_rdy  in  INOUTPORT_NUM  FU of the lane can take a micro-op next cycle.
- o_rf_rd_en  out  RFREAD_PORTS  read enable.
- o_rf_rd_idx  out  RFREAD_PORTS x iprIdx_t  read address.
- i_rf_rd_data  in  RFREAD_PORTS x 64  synchronous-read data, valid the cycle after the request.
- i_wb_vld, i_wb_rdIdx, i_wb_data  in  WBPORT_NUM x (1, iprIdx_t, 64)  writeback broadcast.
- i_squash  in  1  pipeline flush.
- o_fu_vld  out  INOUTPORT_NUM  micro-op valid to the FU.
- o_fu_info  out  per lane  micOp_type, rdIdx, rd_wen, imm, src_val[NUMSRCS].
- o_replay_cnt  out  32  saturating count of replays.

## Operation
Stage S1 (combinational on the RS-issued inputs):
- A source needs a port iff src_use=1 and rsIdx!=0.
  - Register 0 reads as 0 and is always ready.
- Source ready = i_prf_rdy[rsIdx], plus a writeback match when the bypass is enabled (see Configuration).
- Port allocation:
  - Ports are granted in fixed priority: lane 0 src0, lane 0 src1, lane 1 src0, and so on.
  - Ports are granted only to lanes that are valid, have all sources ready, and have i_fu_rdy set.
  - A lane is granted only if all of its needed sources fit in the remaining ports. There is no partial grant and no sharing of identical indices.
  - Port k is driven with o_rf_rd_en[k]=1 and o_rf_rd_idx[k]=rsIdx.
- Per-lane feedback:
  - o_deq_vld[j] = can_issue & all ready & fu_rdy & granted & !i_squash.
  - o_replay_vld[j] = can_issue & !o_deq_vld[j] & !i_squash.
  - Never both set on the same lane. Both are 0 when !i_can_issue[j].
- A dequeued lane's info and its port map (source -> port number, or zero) are registered into S2.

Stage S2:
- o_fu_vld[j] = S2 valid.
- src_val = i_rf_rd_data[mapped port], or 0 for an unused or zero-register source.

Replay counter:
- o_replay_cnt increments by popcount(o_replay_vld) each cycle.
- It saturates at 0xFFFFFFFF.

## Timing
- T0: RS selects. T1: this block sees i_can_issue, drives rf reads and feedback; feedback is combinational and the RS applies it at the T1 edge. T2: o_fu_vld plus operands.
- Issue-to-FU latency is one cycle. Throughput is INOUTPORT_NUM per cycle.
- i_squash in T1:
  - Feedback is 0.
  - S2 is cleared at the edge, so o_fu_vld=0 in T2.
  - A micro-op already in S2 during the squash cycle is also invalidated that cycle (o_fu_vld forced to 0).
- Reset values:
  - S2 valid=0, o_fu_vld=0, o_replay_cnt=0.
  - o_deq_vld, o_replay_vld and o_rf_rd_en are forced to 0 while rst=1.
  - Deassertion mid-stream starts with an empty S2.
- Port exhaustion: a lower-priority lane replays even when its sources are ready.

## Configuration
- INT_RFREAD_BYPASS_EN defined:
  - In S1, a source is also ready if it matches any i_wb_vld/i_wb_rdIdx that cycle.
  - Those sources are not given a port. The matching i_wb_data is captured into S2 and used as src_val.
- Undefined:
  - Readiness comes from i_prf_rdy only.
  - All operands come from the regfile, which must be write-before-read visible the next cycle.
  - The i_wb_* ports are unused.

## Structure
- RSdeqInfo_t, iprIdx_t and the FU-info struct belong in the shared issue package (issue_define.svh).
- Also in that package: the port-map type, width $clog2(RFREAD_PORTS+1).
- One sub-module, rfread_port_alloc: a combinational prefix allocator that takes per-source requests and lane eligibility and returns grants and the port map.

## Test plan
- Reset: hold rst 3 cycles with i_can_issue=11 -> all feedback 0, o_fu_vld=00, o_replay_cnt=0.
- Two lanes, sources p5/p6 and p7/x0, all ready, RFREAD_PORTS=3 -> deq=11 in T1, reads p5,p6,p7; T2 o_fu_vld=11, lane1 src1=0.
- Two lanes, four real sources, 3 ports -> lane0 deq, lane1 replay, o_replay_cnt=1.
- Lane0 src p9 with i_prf_rdy[9]=0 and no writeback -> replay=01, no read issued. With BYPASS_EN and i_wb_rdIdx=9 -> deq, src_val=wb data.
- i_fu_rdy=10 -> lane0 replay, lane1 deq.
- i_squash in T1 with a valid S2 -> feedback 0, o_fu_vld=00 in T1 and T2.

Source files
------------

// File: rtl/int_issue_rfread_pkg.sv
// Shared issue-stage types and sizing for the integer regfile-read stage.
// Optional writeback bypass is selected with INT_RFREAD_BYPASS_EN.
package int_issue_rfread_pkg;

  localparam int DEPTH         = 8;
  localparam int INOUTPORT_NUM = 2;
  localparam int NUMSRCS       = 2;
  localparam int RFREAD_PORTS  = 3;
  localparam int WBPORT_NUM    = 6;
  localparam int PRF_NUM       = 64;

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PRF_W  = $clog2(PRF_NUM);
  localparam int PMAP_W = $clog2(RFREAD_PORTS + 1);

  typedef logic [PRF_W-1:0]  iprIdx_t;
  // 0 = no port, k+1 = regfile read port k
  typedef logic [PMAP_W-1:0] port_map_t;

  typedef enum logic [2:0] {
    MOP_ALU = 3'd0,
    MOP_BRU = 3'd1,
    MOP_MUL = 3'd2,
    MOP_DIV = 3'd3,
    MOP_CSR = 3'd4
  } micOp_t;

  typedef struct packed {
    micOp_t                  micOp_type;
    iprIdx_t [NUMSRCS-1:0]   rsIdx;
    logic [NUMSRCS-1:0]      src_use;
    iprIdx_t                 rdIdx;
    logic                    rd_wen;
    logic [63:0]             imm;
  } RSdeqInfo_t;

  typedef struct packed {
    micOp_t                      micOp_type;
    iprIdx_t                     rdIdx;
    logic                        rd_wen;
    logic [63:0]                 imm;
    logic [NUMSRCS-1:0][63:0]    src_val;
  } fuInfo_t;

  typedef struct packed {
    micOp_t                  micOp_type;
    iprIdx_t                 rdIdx;
    logic                    rd_wen;
    logic [63:0]             imm;
    port_map_t [NUMSRCS-1:0] pmap;
  } s2Entry_t;

  function automatic logic [31:0] popcount_lanes(input logic [INOUTPORT_NUM-1:0] v);
    logic [31:0] sum;
    sum = 32'd0;
    for (int i = 0; i < INOUTPORT_NUM; i++) begin
      sum = sum + 32'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/int_issue_rfread_if.sv
// RS issue channel: selected entries in, dequeue/replay feedback out.
interface int_issue_rfread_if;
  import int_issue_rfread_pkg::*;

  logic [INOUTPORT_NUM-1:0]             i_can_issue;
  logic [INOUTPORT_NUM-1:0][IDX_W-1:0]  i_issue_idx;
  RSdeqInfo_t [INOUTPORT_NUM-1:0]       i_issue_info;
  logic [INOUTPORT_NUM-1:0][IDX_W-1:0]  o_feedback_idx;
  logic [INOUTPORT_NUM-1:0]             o_deq_vld;
  logic [INOUTPORT_NUM-1:0]             o_replay_vld;

  modport master (
    output i_can_issue, i_issue_idx, i_issue_info,
    input  o_feedback_idx, o_deq_vld, o_replay_vld
  );

  modport slave (
    input  i_can_issue, i_issue_idx, i_issue_info,
    output o_feedback_idx, o_deq_vld, o_replay_vld
  );

endinterface

// File: rtl/int_issue_rfread_port_alloc.sv
// Fixed-priority prefix allocator of regfile read ports: a lane is granted
// only when every port-needing source of it fits into the remaining ports.
module rfread_port_alloc
  import int_issue_rfread_pkg::*;
(
  input  logic [INOUTPORT_NUM-1:0][NUMSRCS-1:0] req,
  input  logic [INOUTPORT_NUM-1:0]              lane_elig,
  output logic [INOUTPORT_NUM-1:0]              grant,
  output port_map_t [INOUTPORT_NUM-1:0][NUMSRCS-1:0] pmap
);

  int used_s;
  int need_s;

  // walk lanes in priority order, consuming ports only for granted lanes
  always_comb begin
    grant  = '0;
    pmap   = '0;
    used_s = 0;
    need_s = 0;
    for (int j = 0; j < INOUTPORT_NUM; j++) begin
      need_s = 0;
      for (int s = 0; s < NUMSRCS; s++) begin
        need_s = need_s + int'(req[j][s]);
      end
      if (lane_elig[j] && ((used_s + need_s) <= RFREAD_PORTS)) begin
        grant[j] = 1'b1;
        for (int s = 0; s < NUMSRCS; s++) begin
          if (req[j][s]) begin
            pmap[j][s] = port_map_t'(used_s + 1);
            used_s     = used_s + 1;
          end else begin
            pmap[j][s] = '0;
          end
        end
      end else begin
        grant[j] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/int_issue_rfread.sv
// Integer regfile-read stage: S1 readiness/port allocation/feedback, S2 operands to FUs.
// INT_RFREAD_BYPASS_EN adds same-cycle writeback readiness and operand capture.
module int_issue_rfread
  import int_issue_rfread_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  int_issue_rfread_if.slave                   rs,
  input  logic [PRF_NUM-1:0]                  i_prf_rdy,
  input  logic [INOUTPORT_NUM-1:0]            i_fu_rdy,
  output logic [RFREAD_PORTS-1:0]             o_rf_rd_en,
  output iprIdx_t [RFREAD_PORTS-1:0]          o_rf_rd_idx,
  input  logic [RFREAD_PORTS-1:0][63:0]       i_rf_rd_data,
  input  logic [WBPORT_NUM-1:0]               i_wb_vld,
  input  iprIdx_t [WBPORT_NUM-1:0]            i_wb_rdIdx,
  input  logic [WBPORT_NUM-1:0][63:0]         i_wb_data,
  input  logic                                i_squash,
  output logic [INOUTPORT_NUM-1:0]            o_fu_vld,
  output fuInfo_t [INOUTPORT_NUM-1:0]         o_fu_info,
  output logic [31:0]                         o_replay_cnt
);

  logic [INOUTPORT_NUM-1:0][NUMSRCS-1:0] need_s, req_s, src_rdy_s, wb_hit_s;
  logic [INOUTPORT_NUM-1:0]              elig_s, grant_s, deq_s, replay_s;
  port_map_t [INOUTPORT_NUM-1:0][NUMSRCS-1:0] pmap_s;
  logic [INOUTPORT_NUM-1:0]              s2_vld_r;
  s2Entry_t [INOUTPORT_NUM-1:0]          s2_r;
  logic [32:0]                           cnt_sum_s;
  logic [31:0]                           replay_cnt_r;

`ifdef INT_RFREAD_BYPASS_EN
  logic [INOUTPORT_NUM-1:0][NUMSRCS-1:0][63:0] wb_dat_s;
  logic [INOUTPORT_NUM-1:0][NUMSRCS-1:0][63:0] s2_bdat_r;
  logic [INOUTPORT_NUM-1:0][NUMSRCS-1:0]       s2_byp_r;
`else
  logic unused_wb_s;
  assign unused_wb_s = ^{i_wb_vld, i_wb_rdIdx, i_wb_data};
`endif

  // per-source port need, writeback hit and readiness
  always_comb begin
    need_s    = '0;
    req_s     = '0;
    src_rdy_s = '0;
    wb_hit_s  = '0;
`ifdef INT_RFREAD_BYPASS_EN
    wb_dat_s  = '0;
`endif
    for (int j = 0; j < INOUTPORT_NUM; j++) begin
      for (int s = 0; s < NUMSRCS; s++) begin
        need_s[j][s] = rs.i_issue_info[j].src_use[s] && (rs.i_issue_info[j].rsIdx[s] != '0);
`ifdef INT_RFREAD_BYPASS_EN
        for (int w = 0; w < WBPORT_NUM; w++) begin
          if (i_wb_vld[w] && (i_wb_rdIdx[w] == rs.i_issue_info[j].rsIdx[s])) begin
            wb_hit_s[j][s] = 1'b1;
            wb_dat_s[j][s] = i_wb_data[w];
          end else begin
            wb_hit_s[j][s] = wb_hit_s[j][s];
          end
        end
`endif
        src_rdy_s[j][s] = !need_s[j][s] || i_prf_rdy[rs.i_issue_info[j].rsIdx[s]] || wb_hit_s[j][s];
        req_s[j][s]     = need_s[j][s] && !wb_hit_s[j][s];
      end
    end
  end

  // lane eligibility and dequeue/replay feedback
  always_comb begin
    elig_s   = '0;
    deq_s    = '0;
    replay_s = '0;
    for (int j = 0; j < INOUTPORT_NUM; j++) begin
      elig_s[j]   = rs.i_can_issue[j] && (&src_rdy_s[j]) && i_fu_rdy[j];
      deq_s[j]    = elig_s[j] && grant_s[j] && !i_squash && !rst;
      replay_s[j] = rs.i_can_issue[j] && !deq_s[j] && !i_squash && !rst;
    end
  end

  assign rs.o_deq_vld      = deq_s;
  assign rs.o_replay_vld   = replay_s;
  assign rs.o_feedback_idx = rs.i_issue_idx;

  rfread_port_alloc u_alloc (
    .req       (req_s),
    .lane_elig (elig_s),
    .grant     (grant_s),
    .pmap      (pmap_s)
  );

  // drive regfile read ports from the port map
  always_comb begin
    o_rf_rd_en  = '0;
    o_rf_rd_idx = '0;
    for (int j = 0; j < INOUTPORT_NUM; j++) begin
      for (int s = 0; s < NUMSRCS; s++) begin
        if (!rst && (pmap_s[j][s] != '0)) begin
          o_rf_rd_en[int'(pmap_s[j][s]) - 1]  = 1'b1;
          o_rf_rd_idx[int'(pmap_s[j][s]) - 1] = rs.i_issue_info[j].rsIdx[s];
        end else begin
          o_rf_rd_en = o_rf_rd_en;
        end
      end
    end
  end

  // S2 valid: squash and reset empty the stage
  always_ff @(posedge clk) begin
    if (rst || i_squash) begin
      s2_vld_r <= '0;
    end else begin
      s2_vld_r <= deq_s;
    end
  end

  // S2 payload captured for dequeued lanes
  always_ff @(posedge clk) begin
    for (int j = 0; j < INOUTPORT_NUM; j++) begin
      if (deq_s[j]) begin
        s2_r[j].micOp_type <= rs.i_issue_info[j].micOp_type;
        s2_r[j].rdIdx      <= rs.i_issue_info[j].rdIdx;
        s2_r[j].rd_wen     <= rs.i_issue_info[j].rd_wen;
        s2_r[j].imm        <= rs.i_issue_info[j].imm;
        s2_r[j].pmap       <= pmap_s[j];
`ifdef INT_RFREAD_BYPASS_EN
        s2_byp_r[j]        <= need_s[j] & wb_hit_s[j];
        s2_bdat_r[j]       <= wb_dat_s[j];
`endif
      end
    end
  end

  // S2 outputs; a squash in this cycle also kills the FU valid
  always_comb begin
    o_fu_vld  = '0;
    o_fu_info = '0;
    for (int j = 0; j < INOUTPORT_NUM; j++) begin
      o_fu_vld[j]             = s2_vld_r[j] && !i_squash && !rst;
      o_fu_info[j].micOp_type = s2_r[j].micOp_type;
      o_fu_info[j].rdIdx      = s2_r[j].rdIdx;
      o_fu_info[j].rd_wen     = s2_r[j].rd_wen;
      o_fu_info[j].imm        = s2_r[j].imm;
      for (int s = 0; s < NUMSRCS; s++) begin
        if (s2_r[j].pmap[s] != '0) begin
          o_fu_info[j].src_val[s] = i_rf_rd_data[int'(s2_r[j].pmap[s]) - 1];
        end
`ifdef INT_RFREAD_BYPASS_EN
        else if (s2_byp_r[j][s]) begin
          o_fu_info[j].src_val[s] = s2_bdat_r[j][s];
        end
`endif
        else begin
          o_fu_info[j].src_val[s] = 64'd0;
        end
      end
    end
  end

  assign cnt_sum_s = {1'b0, replay_cnt_r} + {1'b0, popcount_lanes(replay_s)};

  // saturating replay counter
  always_ff @(posedge clk) begin
    if (rst) begin
      replay_cnt_r <= 32'd0;
    end else if (cnt_sum_s[32]) begin
      replay_cnt_r <= 32'hFFFF_FFFF;
    end else begin
      replay_cnt_r <= cnt_sum_s[31:0];
    end
  end

  assign o_replay_cnt = replay_cnt_r;

endmodule
